// File: rtl/bus_cycle_seq.sv
// bus_cycle_seq: round-robin CPU/front-panel bus cycle sequencer (LOAD, STROBE, WAIT, END).
module bus_cycle_seq #(
  parameter int STROBE_CYCLES = 2,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_req,
  input  logic        cpu_io,
  input  logic [23:0] cpu_addr,
  input  logic        fp_req,
  input  logic        fp_io,
  input  logic [23:0] fp_addr,
  input  logic        nwait,
  output logic        cpu_ack,
  output logic        fp_ack,
  output logic [15:0] ibus_addr,
  output logic [7:0]  aext,
  output logic        nwrite_ar,
  output logic        nmem,
  output logic        nio,
  output logic        busy,
  output logic        grant_fp,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT, END} state_t;
  localparam logic [3:0] S_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [7:0] W_LAST = 8'(WAIT_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [23:0] addr_q, addr_d, sel_addr;
  logic io_q, io_d, gfp_q, gfp_d, last_fp_q, last_fp_d, pick_fp, tmo;
  logic nwrite_ar_q, nwrite_ar_d, nmem_q, nmem_d, nio_q, nio_d, busy_q, busy_d;
  logic grant_fp_q, grant_fp_d, cpu_ack_q, cpu_ack_d, fp_ack_q, fp_ack_d, to_q, to_d, strobe_d;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      io_q        <= 1'b0;
      gfp_q       <= 1'b0;
      last_fp_q   <= 1'b0;
      nwrite_ar_q <= 1'b1;
      nmem_q      <= 1'b1;
      nio_q       <= 1'b1;
      busy_q      <= 1'b0;
      grant_fp_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      fp_ack_q    <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      io_q        <= io_d;
      gfp_q       <= gfp_d;
      last_fp_q   <= last_fp_d;
      nwrite_ar_q <= nwrite_ar_d;
      nmem_q      <= nmem_d;
      nio_q       <= nio_d;
      busy_q      <= busy_d;
      grant_fp_q  <= grant_fp_d;
      cpu_ack_q   <= cpu_ack_d;
      fp_ack_q    <= fp_ack_d;
      to_q        <= to_d;
    end
  end
  // last_fp_q remembers the previous winner; FP wins ties unless it won last time
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    io_d      = io_q;
    gfp_d     = gfp_q;
    last_fp_d = last_fp_q;
    tmo       = 1'b0;
    pick_fp   = fp_req & (~cpu_req | ~last_fp_q);
    sel_addr  = pick_fp ? fp_addr : cpu_addr;
    case (state_q)
      IDLE: if (cpu_req | fp_req) begin
        state_d   = LOAD;
        gfp_d     = pick_fp;
        last_fp_d = pick_fp;
        io_d      = pick_fp ? fp_io : cpu_io;
        addr_d    = {io_d ? 8'h00 : sel_addr[23:16], sel_addr[15:0]};
      end
      LOAD: begin
        state_d = STROBE;
        scnt_d  = '0;
      end
      STROBE: if (scnt_q == S_LAST) begin
        state_d = nwait ? END : WAIT;
        wcnt_d  = '0;
      end else scnt_d = scnt_q + 4'd1;
      WAIT: begin
        tmo     = ~nwait & (wcnt_q == W_LAST);
        state_d = (nwait | tmo) ? END : WAIT;
        wcnt_d  = wcnt_q + 8'd1;
      end
      END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so the registers line up with state_q
  always_comb begin
    strobe_d    = (state_d == STROBE) | (state_d == WAIT);
    nwrite_ar_d = state_d != LOAD;
    nmem_d      = ~(strobe_d & ~io_d);
    nio_d       = ~(strobe_d & io_d);
    busy_d      = state_d != IDLE;
    grant_fp_d  = busy_d & gfp_d;
    cpu_ack_d   = (state_d == END) & ~gfp_d;
    fp_ack_d    = (state_d == END) & gfp_d;
    to_d        = (state_d == END) & tmo;
  end
  assign cpu_ack     = cpu_ack_q;
  assign fp_ack      = fp_ack_q;
  assign ibus_addr   = addr_q[15:0];
  assign aext        = addr_q[23:16];
  assign nwrite_ar   = nwrite_ar_q;
  assign nmem        = nmem_q;
  assign nio         = nio_q;
  assign busy        = busy_q;
  assign grant_fp    = grant_fp_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_bus_cycle_seq.sv
// tb_bus_cycle_seq: transaction-level reference model checks of bus_cycle_seq.
module tb_bus_cycle_seq;
  localparam int SC = 2;
  localparam int WT = 255;
  logic clk = 1'b0, nreset = 1'b0;
  logic cpu_req = 1'b0, cpu_io = 1'b0, fp_req = 1'b0, fp_io = 1'b0, nwait = 1'b1;
  logic [23:0] cpu_addr = '0, fp_addr = '0;
  logic cpu_ack, fp_ack, nwrite_ar, nmem, nio, busy, grant_fp, timeout_err;
  logic [15:0] ibus_addr;
  logic [7:0] aext;
  int n_tests = 0, n_fail = 0;
  bit last_fp = 1'b0;
  bus_cycle_seq #(.STROBE_CYCLES(SC), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_io(cpu_io), .cpu_addr(cpu_addr),
    .fp_req(fp_req), .fp_io(fp_io), .fp_addr(fp_addr),
    .nwait(nwait), .cpu_ack(cpu_ack), .fp_ack(fp_ack),
    .ibus_addr(ibus_addr), .aext(aext), .nwrite_ar(nwrite_ar),
    .nmem(nmem), .nio(nio), .busy(busy), .grant_fp(grant_fp),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] obs();
    return {nwrite_ar, nmem, nio, busy, grant_fp, cpu_ack, fp_ack, timeout_err, aext, ibus_addr};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset", obs(), 32'hE000_0000);
    nreset = 1'b1;
    last_fp = 1'b0;
  endtask
  // One granted cycle: k = number of nwait=0 samples starting at the last STROBE clock
  task automatic txn(input bit cr, input bit fr, input bit cio, input bit fio,
                     input logic [23:0] ca, input logic [23:0] fa, input int k, input int rst_at);
    bit wf, io, to;
    int w, len;
    logic [23:0] a, ea;
    cpu_req = cr; fp_req = fr; cpu_io = cio; fp_io = fio;
    cpu_addr = ca; fp_addr = fa; nwait = 1'b1;
    wf  = fr && (!cr || !last_fp);
    a   = wf ? fa : ca;
    io  = wf ? fio : cio;
    ea  = io ? {8'h00, a[15:0]} : a;
    w   = (k > WT) ? WT : k;
    to  = k > WT;
    len = 2 + SC + w;
    for (int c = 1; c <= len; c++) begin
      nwait = !((c - 1) >= SC + 1 && (c - 1) <= SC + k);
      @(posedge clk);
      @(negedge clk);
      if (c == 1) chk("load", obs(), {4'b0111, wf, 3'b000, ea});
      else if (c < len) chk("strobe", obs(), {1'b1, io, !io, 1'b1, wf, 3'b000, ea});
      else chk("end", obs(), {4'b1111, wf, !wf, wf, to, ea});
      if (c == 2 && !(wf ? cr : fr)) begin
        if (wf) cpu_req = 1'b1; else fp_req = 1'b1;
      end
      if (c == 3 && !(wf ? cr : fr)) begin
        if (wf) cpu_req = 1'b0; else fp_req = 1'b0;
      end
      if (c == rst_at) begin
        nwait = 1'b1;
        do_reset();
        return;
      end
      if (c == len && $urandom_range(1) == 1) begin
        if (wf) fp_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    nwait = 1'b1;
    last_fp = wf;
    @(posedge clk);
    @(negedge clk);
    chk("idle", {obs() & 32'hFF00_0000}, 32'hE000_0000);
  endtask
  initial begin
    bit cr, fr;
    do_reset();
    txn(1, 0, 0, 0, 24'h031234, 24'h000000, 0, 0);
    txn(0, 1, 0, 1, 24'h000000, 24'h7F0201, 0, 0);
    do_reset();
    repeat (3) txn(1, 1, 0, 1, 24'hABCDEF, 24'h123456, 0, 0);
    txn(1, 0, 1, 0, 24'h55AA33, 24'h000000, 5, 0);
    txn(0, 1, 0, 0, 24'h000000, 24'hC0FFEE, 300, 0);
    txn(1, 1, 0, 0, 24'h111111, 24'h222222, 0, 2);
    txn(1, 1, 1, 0, 24'h333333, 24'h444444, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cr = 1'($urandom_range(1));
      fr = 1'($urandom_range(1));
      if (!cr && !fr) cr = 1'b1;
      txn(cr, fr, 1'($urandom_range(1)), 1'($urandom_range(1)), 24'($urandom), 24'($urandom),
          ($urandom_range(7) == 0) ? int'($urandom_range(WT + 3, WT - 2)) : int'($urandom_range(6)),
          ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
